sc_regmode_general: RTL and testbench
=====================================

SC_REGMODE_GENERAL -- requirements
Module: sc_regmode_general

Interface
REQ-001 SHALL provide parameter RegMODE_DATAWIDTH, default 8, bit width of every register word.
REQ-002 SHALL provide parameter RegMODE_DEPTH, default 4, number of words in the bank (legal 2..16).
REQ-003 SHALL provide parameter RegMODE_RESETVALUE, default 15, value loaded into every word on reset, truncated to DATAWIDTH.
REQ-004 SHALL derive RegMODE_ADDRWIDTH = clog2(DEPTH), minimum 1.
REQ-005 SC_RegGENERAL_CLOCK_50  input  1  clock; all state updates on its rising edge.
REQ-006 SC_RegGENERAL_RESET_InHigh  input  1  reset, asynchronous, active-high.
REQ-007 SC_RegMODE_clear_InLow  input  1  synchronous clear of addressed word, active-low.
REQ-008 SC_RegMODE_load_InLow  input  1  operation enable, active-low.
REQ-009 SC_RegMODE_mode_InBUS  input  3  operation select.
REQ-010 SC_RegMODE_wrAddr_InBUS  input  ADDRWIDTH  target word of clear/operation.
REQ-011 SC_RegMODE_rdAddr_InBUS  input  ADDRWIDTH  word presented on data output.
REQ-012 SC_RegMODE_data_InBUS  input  DATAWIDTH  parallel load data.
REQ-013 SC_RegMODE_serial_In  input  1  fill bit for shift modes.
REQ-014 SC_RegMODE_data_OutBUS  output  DATAWIDTH  content of word rdAddr.
REQ-015 SC_RegMODE_carry_Out  output  1  registered carry/shift-out flag.
REQ-016 SC_RegMODE_zero_Out  output  1  high when data_OutBUS equals 0.

Function
REQ-017 Priority per edge SHALL be: reset > clear_InLow=0 > load_InLow=0 > hold.
REQ-018 clear_InLow=0 SHALL write 0 to word wrAddr and clear carry, regardless of load and mode.
REQ-019 With clear_InLow=1 and load_InLow=0, word wrAddr SHALL be updated per mode: 000 hold; 001 data_InBUS; 010 shift left, LSB=serial_In; 011 shift right, MSB=serial_In; 100 rotate left; 101 rotate right; 110 +1 modulo 2^DATAWIDTH; 111 -1 modulo 2^DATAWIDTH.
REQ-020 Carry SHALL update only on enabled operations: shift/rotate modes = bit shifted out (old MSB for left, old LSB for right); 110 = 1 iff old word was all-ones; 111 = 1 iff old word was 0; 000/001 = carry cleared.
REQ-021 With load_InLow=1 and clear_InLow=1, all words and carry SHALL hold.
REQ-022 Only word wrAddr SHALL change per cycle; all other words hold.
REQ-023 wrAddr >= DEPTH SHALL make clear/operation a no-op on all words and carry.
REQ-024 data_OutBUS SHALL be combinational from bank[rdAddr]; rdAddr >= DEPTH SHALL read 0.
REQ-025 A write to word N SHALL be visible on data_OutBUS (rdAddr=N) in the cycle after the edge; no same-cycle bypass.
REQ-026 zero_Out SHALL be combinational, derived from data_OutBUS.
REQ-027 Increment/decrement SHALL wrap, never saturate.

Reset
REQ-028 Reset assertion SHALL immediately set every word to RESETVALUE and carry to 0, independent of clock.
REQ-029 During reset all inputs SHALL be ignored; first update occurs on the first rising edge after deassertion.
REQ-030 Reset asserted mid-operation SHALL override any in-flight write on that edge.

Verification
REQ-031 Reset pulse, defaults -> all words read 15 (0x0F), carry=0, zero_Out=0.
REQ-032 Word 2 load 0xA5 (mode 001), then mode 010, serial_In=0 -> word 2 = 0x4A, carry=1; mode 101 -> 0x25, carry=0.
REQ-033 Word 1 load 0xFF, mode 110 -> word 1 = 0x00, carry=1, zero_Out=1 with rdAddr=1; then mode 111 -> 0xFF, carry=1.
REQ-034 clear_InLow=0, load_InLow=0, mode 001, data 0x33, wrAddr=3 -> word 3 = 0x00, words 0-2 unchanged, carry=0.
REQ-035 load_InLow=1 for 5 cycles with varying mode/data -> all words and carry unchanged.
REQ-036 DEPTH=3: write to wrAddr=3 -> no word changes; rdAddr=3 -> data_OutBUS=0, zero_Out=1.

Source files
------------

// File: rtl/sc_regmode_general.sv
// sc_regmode_general: multi-word register bank with per-word load/shift/rotate/count
// operations, a shared carry flag and a combinational read port.
module sc_regmode_general #(
    parameter int RegMODE_DATAWIDTH  = 8,
    parameter int RegMODE_DEPTH      = 4,
    parameter int RegMODE_RESETVALUE = 15,
    parameter int RegMODE_ADDRWIDTH  = (RegMODE_DEPTH > 2) ? $clog2(RegMODE_DEPTH) : 1
) (
    input  logic                         SC_RegGENERAL_CLOCK_50,
    input  logic                         SC_RegGENERAL_RESET_InHigh,
    input  logic                         SC_RegMODE_clear_InLow,
    input  logic                         SC_RegMODE_load_InLow,
    input  logic [2:0]                   SC_RegMODE_mode_InBUS,
    input  logic [RegMODE_ADDRWIDTH-1:0] SC_RegMODE_wrAddr_InBUS,
    input  logic [RegMODE_ADDRWIDTH-1:0] SC_RegMODE_rdAddr_InBUS,
    input  logic [RegMODE_DATAWIDTH-1:0] SC_RegMODE_data_InBUS,
    input  logic                         SC_RegMODE_serial_In,
    output logic [RegMODE_DATAWIDTH-1:0] SC_RegMODE_data_OutBUS,
    output logic                         SC_RegMODE_carry_Out,
    output logic                         SC_RegMODE_zero_Out
);
    localparam int W = RegMODE_DATAWIDTH;

    logic [W-1:0] bank [RegMODE_DEPTH];
    logic [W-1:0] curWord, nextWord;
    logic         nextCarry, wrValid, rdValid, writeEn;

    assign wrValid = 32'(SC_RegMODE_wrAddr_InBUS) < RegMODE_DEPTH;
    assign rdValid = 32'(SC_RegMODE_rdAddr_InBUS) < RegMODE_DEPTH;
    assign curWord = wrValid ? bank[SC_RegMODE_wrAddr_InBUS] : '0;
    assign writeEn = wrValid && (!SC_RegMODE_clear_InLow || !SC_RegMODE_load_InLow);

    always_comb begin
        nextWord  = curWord;
        nextCarry = SC_RegMODE_carry_Out;
        case (SC_RegMODE_mode_InBUS)
            3'b000: nextCarry = 1'b0;
            3'b001: {nextCarry, nextWord} = {1'b0, SC_RegMODE_data_InBUS};
            3'b010: {nextCarry, nextWord} = {curWord, SC_RegMODE_serial_In};
            3'b011: {nextWord, nextCarry} = {SC_RegMODE_serial_In, curWord};
            3'b100: {nextCarry, nextWord} = {curWord[W-1], curWord[W-2:0], curWord[W-1]};
            3'b101: {nextCarry, nextWord} = {curWord[0], curWord[0], curWord[W-1:1]};
            3'b110: {nextCarry, nextWord} = {&curWord, curWord + 1'b1};
            default: {nextCarry, nextWord} = {~|curWord, curWord - 1'b1};
        endcase
        // clear outranks any operation selected on the same edge
        if (!SC_RegMODE_clear_InLow) {nextCarry, nextWord} = '0;
    end

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            for (int i = 0; i < RegMODE_DEPTH; i++) bank[i] <= W'(RegMODE_RESETVALUE);
            SC_RegMODE_carry_Out <= 1'b0;
        end else if (writeEn) begin
            bank[SC_RegMODE_wrAddr_InBUS] <= nextWord;
            SC_RegMODE_carry_Out          <= nextCarry;
        end
    end

    assign SC_RegMODE_data_OutBUS = rdValid ? bank[SC_RegMODE_rdAddr_InBUS] : '0;
    assign SC_RegMODE_zero_Out    = SC_RegMODE_data_OutBUS == '0;
endmodule

// File: tb/tb_sc_regmode_general.sv
// tb_sc_regmode_general: table-driven checks of the default bank plus a DEPTH=3
// instance sharing the same stimulus for out-of-range address behaviour.
module tb_sc_regmode_general;
    logic       clk = 1'b0, rst = 1'b1;
    logic       clr = 1'b1, load = 1'b1, ser = 1'b0;
    logic [2:0] mode = '0;
    logic [1:0] wr = '0, rd = '0;
    logic [7:0] data = '0;
    logic [7:0] dOut, dOut3;
    logic       cOut, zOut, cOut3, zOut3;
    int         nChecks = 0, nFails = 0;

    always #5 clk = ~clk;

    sc_regmode_general dut (
        .SC_RegGENERAL_CLOCK_50(clk), .SC_RegGENERAL_RESET_InHigh(rst),
        .SC_RegMODE_clear_InLow(clr), .SC_RegMODE_load_InLow(load),
        .SC_RegMODE_mode_InBUS(mode), .SC_RegMODE_wrAddr_InBUS(wr),
        .SC_RegMODE_rdAddr_InBUS(rd), .SC_RegMODE_data_InBUS(data),
        .SC_RegMODE_serial_In(ser), .SC_RegMODE_data_OutBUS(dOut),
        .SC_RegMODE_carry_Out(cOut), .SC_RegMODE_zero_Out(zOut)
    );

    sc_regmode_general #(.RegMODE_DEPTH(3)) dut3 (
        .SC_RegGENERAL_CLOCK_50(clk), .SC_RegGENERAL_RESET_InHigh(rst),
        .SC_RegMODE_clear_InLow(clr), .SC_RegMODE_load_InLow(load),
        .SC_RegMODE_mode_InBUS(mode), .SC_RegMODE_wrAddr_InBUS(wr),
        .SC_RegMODE_rdAddr_InBUS(rd), .SC_RegMODE_data_InBUS(data),
        .SC_RegMODE_serial_In(ser), .SC_RegMODE_data_OutBUS(dOut3),
        .SC_RegMODE_carry_Out(cOut3), .SC_RegMODE_zero_Out(zOut3)
    );

    typedef struct {
        logic       clr, load;
        logic [2:0] mode;
        logic [1:0] wr, rd;
        logic [7:0] data;
        logic       ser;
        logic [7:0] expD;
        logic       expC, expZ;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 3'd1, 2'd2, 2'd2, 8'hA5, 0, 8'hA5, 0, 0};
        vecs[1]  = '{1, 0, 3'd2, 2'd2, 2'd2, 8'h00, 0, 8'h4A, 1, 0};
        vecs[2]  = '{1, 0, 3'd5, 2'd2, 2'd2, 8'h00, 0, 8'h25, 0, 0};
        vecs[3]  = '{1, 0, 3'd1, 2'd1, 2'd1, 8'hFF, 0, 8'hFF, 0, 0};
        vecs[4]  = '{1, 0, 3'd6, 2'd1, 2'd1, 8'h00, 0, 8'h00, 1, 1};
        vecs[5]  = '{1, 0, 3'd7, 2'd1, 2'd1, 8'h00, 0, 8'hFF, 1, 0};
        vecs[6]  = '{1, 0, 3'd3, 2'd2, 2'd2, 8'h00, 1, 8'h92, 1, 0};
        vecs[7]  = '{1, 0, 3'd4, 2'd2, 2'd2, 8'h00, 0, 8'h25, 1, 0};
        vecs[8]  = '{1, 0, 3'd0, 2'd2, 2'd2, 8'h5A, 0, 8'h25, 0, 0};
        vecs[9]  = '{1, 0, 3'd6, 2'd0, 2'd0, 8'h00, 0, 8'h10, 0, 0};
        vecs[10] = '{1, 0, 3'd7, 2'd3, 2'd3, 8'h00, 0, 8'h0E, 0, 0};
        vecs[11] = '{1, 0, 3'd3, 2'd1, 2'd1, 8'h00, 0, 8'h7F, 1, 0};
        vecs[12] = '{0, 0, 3'd1, 2'd3, 2'd3, 8'h33, 0, 8'h00, 0, 1};
        vecs[13] = '{1, 0, 3'd7, 2'd3, 2'd3, 8'h00, 0, 8'hFF, 1, 0};
        vecs[14] = '{1, 1, 3'd1, 2'd0, 2'd0, 8'h77, 1, 8'h10, 1, 0};
        vecs[15] = '{1, 1, 3'd6, 2'd1, 2'd1, 8'h00, 0, 8'h7F, 1, 0};
        vecs[16] = '{1, 1, 3'd2, 2'd2, 2'd2, 8'hFF, 1, 8'h25, 1, 0};
        vecs[17] = '{1, 1, 3'd7, 2'd3, 2'd3, 8'h12, 0, 8'hFF, 1, 0};
        vecs[18] = '{1, 1, 3'd4, 2'd3, 2'd0, 8'hAA, 1, 8'h10, 1, 0};
        vecs[19] = '{0, 1, 3'd5, 2'd0, 2'd0, 8'h00, 0, 8'h00, 0, 1};
        vecs[20] = '{1, 0, 3'd6, 2'd0, 2'd0, 8'h00, 0, 8'h01, 0, 0};

        // reset defaults
        #12;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rd = 2'(i);
            #1;
            check($sformatf("reset word%0d", i), {24'h0, dOut}, 32'h0F);
        end
        check("reset carry", {31'h0, cOut}, 32'h0);
        check("reset zero", {31'h0, zOut}, 32'h0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            {clr, load, mode, wr, rd, data, ser} =
                {vecs[i].clr, vecs[i].load, vecs[i].mode, vecs[i].wr, vecs[i].rd, vecs[i].data, vecs[i].ser};
            step();
            check($sformatf("vec%0d data", i), {24'h0, dOut}, {24'h0, vecs[i].expD});
            check($sformatf("vec%0d carry", i), {31'h0, cOut}, {31'h0, vecs[i].expC});
            check($sformatf("vec%0d zero", i), {31'h0, zOut}, {31'h0, vecs[i].expZ});
        end

        // asynchronous reset overrides an in-flight write
        @(negedge clk);
        {clr, load, mode, wr, rd, data} = {1'b1, 1'b0, 3'd1, 2'd0, 2'd0, 8'h55};
        rst = 1'b1;
        #1;
        check("async reset word0", {24'h0, dOut}, 32'h0F);
        check("async reset carry", {31'h0, cOut}, 32'h0);
        step();
        check("reset holds over edge", {24'h0, dOut}, 32'h0F);
        @(negedge clk);
        load = 1'b1;
        rst  = 1'b0;
        step();
        check("post reset word0", {24'h0, dOut}, 32'h0F);

        // DEPTH=3: out-of-range address leaves words and carry alone
        @(negedge clk);
        {clr, load, mode, wr, data} = {1'b1, 1'b0, 3'd1, 2'd0, 8'h80};
        step();
        @(negedge clk);
        {mode, ser} = {3'd2, 1'b0};
        step();
        check("d3 carry set", {31'h0, cOut3}, 32'h1);
        @(negedge clk);
        {mode, wr, data} = {3'd1, 2'd3, 8'hAA};
        step();
        @(negedge clk);
        clr = 1'b0;
        step();
        @(negedge clk);
        {clr, load} = 2'b11;
        check("d3 carry kept", {31'h0, cOut3}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            rd = 2'(i);
            #1;
            check($sformatf("d3 word%0d", i), {24'h0, dOut3}, (i == 0) ? 32'h00 : 32'h0F);
        end
        rd = 2'd3;
        #1;
        check("d3 rd3 data", {24'h0, dOut3}, 32'h0);
        check("d3 rd3 zero", {31'h0, zOut3}, 32'h1);
        check("d4 word3 cleared", {24'h0, dOut}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
